mod_position_counter: RTL and testbench
=======================================

Name: mod_position_counter

Overview:
- Parametrised modulo position counter for cursor/slot selection driven by keyboard events, e.g. `ps2_key_pressed`.
- Generalises the fixed 2-bit wrap counter to:
  - configurable width and modulus;
  - up/down direction;
  - wrap or saturate mode;
  - synchronous load;
  - terminal-count flags.
- Runs entirely on the system `clk`. The `advance` strobe is synchronised and edge-detected internally, so the keyboard strobe is never used as a clock.

Parameters:
- `WIDTH`, default 2: bit width of `out` and `load_value`.
- `MODULUS`, default 4: count range is 0..MODULUS-1. Requires 2 <= MODULUS <= 2**WIDTH.
- `SYNC_STAGES`, default 2: number of synchroniser flops on `advance`. Minimum 2.
- `DEBOUNCE_CYCLES`, default 16: stability window on `advance`. Used only with the optional feature.

Ports:
- `clk` input 1: system clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: count enable. Ticks arriving while low are dropped.
- `advance` input 1: asynchronous step request. Each rising edge counts one step.
- `dir` input 1: 0 = increment, 1 = decrement. Sampled on the tick cycle.
- `mode` input 1: 0 = wrap, 1 = saturate. Sampled on the tick cycle.
- `load` input 1: synchronous load strobe.
- `load_value` input WIDTH: value written on `load`.
- `out` output WIDTH: current position (registered).
- `wrap_pulse` output 1: one-cycle registered pulse on each wrap-around.
- `at_max` output 1: combinational, high when `out` == MODULUS-1.
- `at_min` output 1: combinational, high when `out` == 0.

Behaviour:
- Reset (async assert, sync-released by the system):
  - `out` = 0, `wrap_pulse` = 0.
  - All sync flops and the edge-detect register = 0.
- Synchroniser and edge detect:
  - `advance` passes through SYNC_STAGES flops. `tick` = synced & ~prev_synced.
  - Latency: `advance` first sampled high at edge k, then `out` updates at edge k+SYNC_STAGES (enable=1, load=0).
  - One tick per rising edge of `advance`, however long it is held high.
  - Pulses shorter than one `clk` period may be missed. This is accepted.
- Update priority on each edge: load, then tick&enable, then hold.
- Load:
  - `out` <= `load_value`. If `load_value` >= MODULUS, `out` <= MODULUS-1 (clamped).
  - `wrap_pulse` <= 0.
  - A tick in the same cycle is discarded, not deferred.
- Tick, dir=0:
  - If `out` < MODULUS-1: `out` <= `out`+1.
  - If `out` == MODULUS-1 and wrap mode: `out` <= 0 and `wrap_pulse` <= 1.
  - If `out` == MODULUS-1 and saturate mode: hold, `wrap_pulse` <= 0.
- Tick, dir=1:
  - If `out` > 0: `out` <= `out`-1.
  - If `out` == 0 and wrap mode: `out` <= MODULUS-1 and `wrap_pulse` <= 1.
  - If `out` == 0 and saturate mode: hold.
- Otherwise `wrap_pulse` <= 0. It is never high for two consecutive cycles unless two consecutive ticks both wrap.
- Arithmetic is performed in WIDTH+1 bits. `out` never holds a value >= MODULUS.
- `enable` low during a tick: the tick is lost. The edge detector still consumes the edge, so re-asserting `enable` does not replay it.
- `advance` held high through reset release: the synced value rises from 0, producing exactly one tick SYNC_STAGES cycles after release.
- Reset asserted mid-synchronisation discards any in-flight tick.
- A `dir` or `mode` change takes effect on the next tick only. No state is re-evaluated retroactively.

Optional Feature:
- Macro: `MOD_POSITION_COUNTER_DEBOUNCE_EN`.
- Defined:
  - A debounce counter of width clog2(DEBOUNCE_CYCLES+1) sits after the synchroniser.
  - The filtered level changes only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle restarts the count.
  - Edge detection operates on the filtered level. Latency grows by DEBOUNCE_CYCLES.
  - The debounce counter and filtered level reset to 0.
- Undefined: no debounce logic. DEBOUNCE_CYCLES is ignored and latency is exactly SYNC_STAGES.

Test Plan:
1. Defaults (WIDTH=2, MODULUS=4), wrap, dir=0, enable=1; 5 `advance` pulses each 3 cycles high / 3 low -> `out` 1,2,3,0,1. `wrap_pulse` high one cycle on the 3->0 step. Each update occurs SYNC_STAGES edges after sampling.
2. WIDTH=4, MODULUS=10, saturate, dir=1, `out`=2; 4 pulses -> `out` 1,0,0,0. `wrap_pulse` stays 0. `at_min`=1 from the second pulse onward.
3. WIDTH=4, MODULUS=10; `load`=1 with `load_value`=13 -> `out`=9, `at_max`=1. Then `load` with 5 in the same cycle as a tick -> `out`=5, tick discarded.
4. `advance` held high for 50 cycles -> exactly one increment. `enable`=0 across one pulse -> `out` unchanged, and no increment when `enable` returns.
5. Reset asserted asynchronously mid-cycle with `out`=3 -> `out`=0 and `wrap_pulse`=0 immediately, without waiting for `clk`. `advance` held high through release -> `out`=1 after SYNC_STAGES edges.
6. With `MOD_POSITION_COUNTER_DEBOUNCE_EN` defined and DEBOUNCE_CYCLES=16: 10-cycle glitch on `advance` -> no change. 20-cycle pulse -> one increment, SYNC_STAGES+16 edges after sampling.

Source files
------------

// File: rtl/mod_position_counter.sv
// mod_position_counter
// ---------------------------------------------------------------------------
// Modulo position counter for cursor/slot selection driven by an asynchronous
// step request such as a keyboard "key pressed" strobe. The strobe is never
// used as a clock: it is synchronised into clk, optionally debounced, and
// rising-edge detected to give a one-cycle tick.
//
// Each clock edge applies the first matching action: load, then tick with
// enable, then hold.
//
// Optional feature: define MOD_POSITION_COUNTER_DEBOUNCE_EN to insert a
// debounce filter of DEBOUNCE_CYCLES between the synchroniser and the edge
// detector. Without the macro, no debounce logic is built and the
// advance-to-out latency is exactly SYNC_STAGES edges.
//
// Parameters:
//   WIDTH           width of out / load_value
//   MODULUS         count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   SYNC_STAGES     synchroniser depth on advance (>= 2)
//   DEBOUNCE_CYCLES stability window, used only with the debounce macro
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   reset       asynchronous active-high reset
//   enable      count enable; ticks arriving while low are dropped
//   advance     asynchronous step request, one step per rising edge
//   dir         0 = increment, 1 = decrement (sampled on the tick cycle)
//   mode        0 = wrap, 1 = saturate (sampled on the tick cycle)
//   load        synchronous load strobe
//   load_value  value written on load, clamped to MODULUS-1
//   out         registered position
//   wrap_pulse  registered one-cycle pulse on each wrap-around
//   at_max      out == MODULUS-1 (combinational)
//   at_min      out == 0 (combinational)
// ---------------------------------------------------------------------------
module mod_position_counter #(
    parameter int WIDTH           = 2,
    parameter int MODULUS         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             advance,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             wrap_pulse,
    output logic             at_max,
    output logic             at_min
);

    // Range constants in WIDTH+1 bits so MODULUS == 2**WIDTH still fits.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // -----------------------------------------------------------------------
    // Synchroniser chain on advance
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_q[gi] <= 1'b0;
                    else       sync_q[gi] <= advance;
                end
            end else begin : g_rest
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_q[gi] <= 1'b0;
                    else       sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    logic synced;
    logic level;     // level fed to the edge detector
    assign synced = sync_q[SYNC_STAGES-1];

`ifdef MOD_POSITION_COUNTER_DEBOUNCE_EN
    // -----------------------------------------------------------------------
    // Debounce: level follows synced only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; a single agreeing cycle restarts the window.
    // -----------------------------------------------------------------------
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_q;
    logic            db_level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else if (synced != db_level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_q <= synced;
                db_cnt_q   <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign level = db_level_q;
`else
    assign level = synced;
`endif

    // -----------------------------------------------------------------------
    // Rising-edge detect. The edge is consumed whether or not enable is high,
    // so a dropped tick is never replayed later.
    // -----------------------------------------------------------------------
    logic prev_q;
    logic tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= level;
    end

    assign tick = level & ~prev_q;

    // -----------------------------------------------------------------------
    // Position register
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   out_ext;

    assign out_ext = {1'b0, out_q};

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load) begin
            // A tick coinciding with load is discarded, not deferred.
            if ({1'b0, load_value} >= MOD_EXT) out_d = MAX_VAL;
            else                               out_d = load_value;
        end else if (tick && enable) begin
            if (!dir) begin
                if (out_ext < MAX_EXT) begin
                    out_d = WIDTH'(out_ext + (WIDTH+1)'(1));
                end else if (!mode) begin
                    out_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (out_ext != '0) begin
                    out_d = WIDTH'(out_ext - (WIDTH+1)'(1));
                end else if (!mode) begin
                    out_d  = MAX_VAL;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out        = out_q;
    assign wrap_pulse = wrap_q;
    assign at_max     = (out_q == MAX_VAL);
    assign at_min     = (out_q == '0);

endmodule

// File: tb/tb_mod_position_counter.sv
module tb_mod_position_counter;

    localparam int SYNC = 2;
`ifdef MOD_POSITION_COUNTER_DEBOUNCE_EN
    localparam int LAT = SYNC + 16;
    localparam int PW  = 20;   // pulses must outlast the debounce window
`else
    localparam int LAT = SYNC;
    localparam int PW  = 3;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    // dut4: defaults (WIDTH=2, MODULUS=4); dut10: WIDTH=4, MODULUS=10
    logic en4 = 1'b1, adv4 = 1'b0, dir4 = 1'b0, mode4 = 1'b0, load4 = 1'b0;
    logic [1:0] lv4 = '0;
    logic [1:0] out4;
    logic wrap4, max4, min4;

    logic en10 = 1'b1, adv10 = 1'b0, dir10 = 1'b0, mode10 = 1'b0, load10 = 1'b0;
    logic [3:0] lv10 = '0;
    logic [3:0] out10;
    logic wrap10, max10, min10;

    always #5 clk = ~clk;

    mod_position_counter #(.WIDTH(2), .MODULUS(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(16)) dut4 (
        .clk(clk), .reset(reset), .enable(en4), .advance(adv4), .dir(dir4), .mode(mode4),
        .load(load4), .load_value(lv4), .out(out4), .wrap_pulse(wrap4), .at_max(max4), .at_min(min4));

    mod_position_counter #(.WIDTH(4), .MODULUS(10), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(16)) dut10 (
        .clk(clk), .reset(reset), .enable(en10), .advance(adv10), .dir(dir10), .mode(mode10),
        .load(load10), .load_value(lv10), .out(out10), .wrap_pulse(wrap10), .at_max(max10), .at_min(min10));

    typedef struct {
        int         sel;
        int         due;
        logic [3:0] out;
        bit         wrap;
    } sb_t;

    sb_t  q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;

    logic [3:0] exp_cur [2];
    bit         exp_wrap [2];
    logic [3:0] obs_out [2];
    logic       obs_wrap [2];
    logic       obs_max [2];
    logic       obs_min [2];
    logic [3:0] top_val [2];

    assign obs_out[0]  = {2'b00, out4};
    assign obs_out[1]  = out10;
    assign obs_wrap[0] = wrap4;
    assign obs_wrap[1] = wrap10;
    assign obs_max[0]  = max4;
    assign obs_max[1]  = max10;
    assign obs_min[0]  = min4;
    assign obs_min[1]  = min10;
    assign top_val[0]  = 4'd3;
    assign top_val[1]  = 4'd9;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every cycle, apply any update due now, then compare both
    // counters against the expected current state.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                exp_wrap[d] = 1'b0;
                for (int j = q.size() - 1; j >= 0; j--) begin
                    if (q[j].sel == d && q[j].due == cyc) begin
                        exp_cur[d]  = q[j].out;
                        exp_wrap[d] = q[j].wrap;
                        q.delete(j);
                    end
                end
                n_vec++;
                if (obs_out[d] !== exp_cur[d] || obs_wrap[d] !== exp_wrap[d] ||
                    obs_max[d] !== (exp_cur[d] == top_val[d]) || obs_min[d] !== (exp_cur[d] == 4'd0)) begin
                    n_err++;
                    $display("FAIL sb dut%0d cycle %0d: got out=%0d wrap=%b max=%b min=%b, expected out=%0d wrap=%b max=%b min=%b",
                             d, cyc, obs_out[d], obs_wrap[d], obs_max[d], obs_min[d],
                             exp_cur[d], exp_wrap[d], (exp_cur[d] == top_val[d]), (exp_cur[d] == 4'd0));
                end
            end
        end
    end

    // One advance pulse on the selected counter. If ticks is set, the
    // expected post-tick state is scheduled SYNC(+debounce) edges after the
    // first edge that samples advance high.
    task automatic pulse(input int sel, input int hi, input int lo, input bit ticks,
                         input logic [3:0] exp_out, input bit exp_w);
        sb_t e;
        @(negedge clk);
        if (sel == 0) adv4 = 1'b1; else adv10 = 1'b1;
        if (ticks) begin
            e.sel = sel; e.due = cyc + 1 + LAT; e.out = exp_out; e.wrap = exp_w;
            q.push_back(e);
        end
        $display("pulse dut%0d hi=%0d lo=%0d tick=%b expect out=%0d wrap=%b", sel, hi, lo, ticks, exp_out, exp_w);
        repeat (hi) @(negedge clk);
        if (sel == 0) adv4 = 1'b0; else adv10 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_load(input int sel, input logic [3:0] v, input logic [3:0] exp_out);
        sb_t e;
        @(negedge clk);
        if (sel == 0) begin load4 = 1'b1; lv4 = v[1:0]; end
        else          begin load10 = 1'b1; lv10 = v; end
        e.sel = sel; e.due = cyc + 1; e.out = exp_out; e.wrap = 1'b0;
        q.push_back(e);
        $display("load dut%0d value=%0d expect out=%0d", sel, v, exp_out);
        @(negedge clk);
        load4 = 1'b0; load10 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (out4 !== 2'd0 || wrap4 !== 1'b0 || min4 !== 1'b1 || max4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset dut4: got out=%0d wrap=%b min=%b max=%b, expected 0 0 1 0", out4, wrap4, min4, max4);
        end
        n_vec++;
        if (out10 !== 4'd0 || wrap10 !== 1'b0 || min10 !== 1'b1 || max10 !== 1'b0) begin
            n_err++;
            $display("FAIL reset dut10: got out=%0d wrap=%b min=%b max=%b, expected 0 0 1 0", out10, wrap10, min10, max10);
        end
        reset = 1'b0;
        exp_cur[0] = 4'd0;
        exp_cur[1] = 4'd0;
        chk_en = 1'b1;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_wrap_up();
        dir4 = 1'b0; mode4 = 1'b0; en4 = 1'b1;
        pulse(0, PW, PW, 1'b1, 4'd1, 1'b0);
        pulse(0, PW, PW, 1'b1, 4'd2, 1'b0);
        pulse(0, PW, PW, 1'b1, 4'd3, 1'b0);
        pulse(0, PW, PW, 1'b1, 4'd0, 1'b1);
        pulse(0, PW, PW, 1'b1, 4'd1, 1'b0);
    endtask

    task automatic test_saturate_down();
        dir10 = 1'b1; mode10 = 1'b1;
        do_load(1, 4'd2, 4'd2);
        pulse(1, PW, PW, 1'b1, 4'd1, 1'b0);
        pulse(1, PW, PW, 1'b1, 4'd0, 1'b0);
        pulse(1, PW, PW, 1'b1, 4'd0, 1'b0);
        pulse(1, PW, PW, 1'b1, 4'd0, 1'b0);
    endtask

    task automatic test_load();
        sb_t e;
        do_load(1, 4'd13, 4'd9);
        repeat (3) @(negedge clk);
        // from 9 in wrap mode a tick would wrap; the coincident load must win
        dir10 = 1'b0; mode10 = 1'b0;
        @(negedge clk);
        adv10 = 1'b1;
        repeat (LAT) @(negedge clk);
        load10 = 1'b1; lv10 = 4'd5;
        e.sel = 1; e.due = cyc + 1; e.out = 4'd5; e.wrap = 1'b0;
        q.push_back(e);
        $display("load dut1 value=5 with coincident tick, expect out=5");
        @(negedge clk);
        load10 = 1'b0;
        repeat (PW) @(negedge clk);
        adv10 = 1'b0;
        repeat (PW + LAT) @(negedge clk);
    endtask

    task automatic test_wrap_down();
        dir10 = 1'b1; mode10 = 1'b0;
        do_load(1, 4'd0, 4'd0);
        pulse(1, PW, PW, 1'b1, 4'd9, 1'b1);
        pulse(1, PW, PW, 1'b1, 4'd8, 1'b0);
    endtask

    task automatic test_hold_and_enable();
        pulse(0, 50, PW, 1'b1, 4'd2, 1'b0);
        @(negedge clk);
        en4 = 1'b0;
        pulse(0, PW, PW + LAT, 1'b0, 4'd2, 1'b0);
        en4 = 1'b1;
        repeat (10) @(negedge clk);
        pulse(0, PW, PW, 1'b1, 4'd3, 1'b0);
    endtask

    task automatic test_async_reset();
        sb_t e;
        @(negedge clk);
        chk_en = 1'b0;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL pending before reset: got %0d queued, expected 0", q.size());
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (out4 !== 2'd0 || wrap4 !== 1'b0 || out10 !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset: got out4=%0d wrap4=%b out10=%0d, expected 0 0 0", out4, wrap4, out10);
        end
        $display("async reset mid-cycle, out4=%0d out10=%0d", out4, out10);
        @(negedge clk);
        adv4 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_cur[0] = 4'd0;
        exp_cur[1] = 4'd0;
        e.sel = 0; e.due = cyc + 1 + LAT; e.out = 4'd1; e.wrap = 1'b0;
        q.push_back(e);
        chk_en = 1'b1;
        $display("reset released with advance high, expect out4=1 at cycle %0d", e.due);
        repeat (LAT + 5) @(negedge clk);
        adv4 = 1'b0;
        repeat (PW + LAT) @(negedge clk);
    endtask

`ifdef MOD_POSITION_COUNTER_DEBOUNCE_EN
    task automatic test_debounce();
        pulse(0, 10, 40, 1'b0, 4'd1, 1'b0);
        pulse(0, 20, 40, 1'b1, 4'd2, 1'b0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_load();
        test_wrap_down();
        test_hold_and_enable();
        test_async_reset();
`ifdef MOD_POSITION_COUNTER_DEBOUNCE_EN
        test_debounce();
`endif
        repeat (LAT + 4) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unconsumed expectations, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
